// File: rtl/decode_pkg.sv
// Shared encodings, field widths and the decoded-record layout for the MIPS decode stage.
package decode_pkg;

    localparam int INSTR_W  = 32;
    localparam int ADDR_W   = 32;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int ITYPE_W  = 2;

    localparam logic [ITYPE_W-1:0] ITYPE_R = 2'd0;
    localparam logic [ITYPE_W-1:0] ITYPE_I = 2'd1;
    localparam logic [ITYPE_W-1:0] ITYPE_J = 2'd2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0E;

    // Immediate is kept outside the record because its width is a per-instance parameter.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [SHAMT_W-1:0]  shamt;
        logic [FUNCT_W-1:0]  funct;
        logic [ITYPE_W-1:0]  itype;
        logic [ADDR_W-1:0]   jump_target;
        logic [ADDR_W-1:0]   pc;
    } dec_rec_t;

    function automatic logic [ITYPE_W-1:0] classify(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE:     return ITYPE_R;
            OP_J, OP_JAL: return ITYPE_J;
            default:      return ITYPE_I;
        endcase
    endfunction

    function automatic logic is_zero_ext(input logic [OPCODE_W-1:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Purpose: split a MIPS word into fields, classify R/I/J, extend the immediate, form the jump target.
// Latency: purely combinational.
// Backpressure: none; sits on the write side of the record FIFO.
module decode_fields
    import decode_pkg::*;
#(
    parameter int IMM_WIDTH = 32
) (
    input  logic [INSTR_W-1:0]   instruction,
    input  logic [ADDR_W-1:0]    pc,
    output dec_rec_t             rec,
    output logic [IMM_WIDTH-1:0] imm
);

    logic [3:0] pc4_hi;

    always_comb begin
        // Upper nibble of pc+4: the +4 carries into bit 28 only when pc[27:2] is all ones.
        pc4_hi          = pc[31:28] + {3'b000, &pc[27:2]};
        rec.opcode      = instruction[31:26];
        rec.rs          = instruction[25:21];
        rec.rt          = instruction[20:16];
        rec.rd          = instruction[15:11];
        rec.shamt       = instruction[10:6];
        rec.funct       = instruction[5:0];
        rec.itype       = classify(instruction[31:26]);
        rec.jump_target = {pc4_hi, instruction[25:0], 2'b00};
        rec.pc          = pc;
        if (is_zero_ext(instruction[31:26]))
            imm = IMM_WIDTH'(instruction[15:0]);
        else
            imm = IMM_WIDTH'($signed(instruction[15:0]));
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: registered MIPS decode stage, decoded records held in a DEPTH-entry FIFO; DECODE_STATS_EN adds per-class push counters.
// Latency: one cycle from an accepted instruction to out_valid when the buffer is empty.
// Backpressure: in_ready = !full (no path from out_ready); flush empties the buffer and drops a same-cycle push.
module decode_stage
    import decode_pkg::*;
#(
    parameter int IMM_WIDTH = 32,
    parameter int DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instruction,
    input  logic [31:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5:0]             out_opcode,
    output logic [4:0]             out_rs,
    output logic [4:0]             out_rt,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_shamt,
    output logic [5:0]             out_funct,
    output logic [IMM_WIDTH-1:0]   out_imm,
    output logic [31:0]            out_jump_target,
    output logic [1:0]             out_itype,
    output logic [31:0]            out_pc,
    output logic [$clog2(DEPTH):0] count
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]            stat_r,
    output logic [31:0]            stat_i,
    output logic [31:0]            stat_j
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    dec_rec_t             in_rec;
    dec_rec_t             head_rec;
    logic [IMM_WIDTH-1:0] in_imm;
    logic [IMM_WIDTH-1:0] head_imm;
    dec_rec_t             rec_mem [DEPTH];
    logic [IMM_WIDTH-1:0] imm_mem [DEPTH];
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    decode_fields #(.IMM_WIDTH(IMM_WIDTH)) u_fields (
        .instruction (in_instruction),
        .pc          (in_pc),
        .rec         (in_rec),
        .imm         (in_imm)
    );

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push      = in_valid && !full;
    assign pop       = out_ready && !empty;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            rec_mem[wr_ptr[PTR_W-1:0]] <= in_rec;
            imm_mem[wr_ptr[PTR_W-1:0]] <= in_imm;
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    always_comb begin
        head_rec = '0;
        head_imm = '0;
        if (!empty) begin
            head_rec = rec_mem[rd_ptr[PTR_W-1:0]];
            head_imm = imm_mem[rd_ptr[PTR_W-1:0]];
        end
    end

    assign out_opcode      = head_rec.opcode;
    assign out_rs          = head_rec.rs;
    assign out_rt          = head_rec.rt;
    assign out_rd          = head_rec.rd;
    assign out_shamt       = head_rec.shamt;
    assign out_funct       = head_rec.funct;
    assign out_itype       = head_rec.itype;
    assign out_jump_target = head_rec.jump_target;
    assign out_pc          = head_rec.pc;
    assign out_imm         = head_imm;

`ifdef DECODE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_r <= '0;
            stat_i <= '0;
            stat_j <= '0;
        end else if (push && !flush) begin
            case (in_rec.itype)
                ITYPE_R: stat_r <= stat_r + 32'd1;
                ITYPE_I: stat_i <= stat_i + 32'd1;
                ITYPE_J: stat_j <= stat_j + 32'd1;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases then random traffic against a queue-based model.
module tb_decode_stage;

    localparam int DEPTH     = 2;
    localparam int IMM_WIDTH = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic [31:0]            in_instruction = '0;
    logic [31:0]            in_pc = '0;
    logic                   in_ready;
    logic                   out_valid;
    logic [5:0]             out_opcode;
    logic [4:0]             out_rs;
    logic [4:0]             out_rt;
    logic [4:0]             out_rd;
    logic [4:0]             out_shamt;
    logic [5:0]             out_funct;
    logic [IMM_WIDTH-1:0]   out_imm;
    logic [31:0]            out_jump_target;
    logic [1:0]             out_itype;
    logic [31:0]            out_pc;
    logic [$clog2(DEPTH):0] count;
`ifdef DECODE_STATS_EN
    logic [31:0]            stat_r;
    logic [31:0]            stat_i;
    logic [31:0]            stat_j;
    int unsigned            m_r = 0;
    int unsigned            m_i = 0;
    int unsigned            m_j = 0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];

    decode_stage #(.IMM_WIDTH(IMM_WIDTH), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_opcode      (out_opcode),
        .out_rs          (out_rs),
        .out_rt          (out_rt),
        .out_rd          (out_rd),
        .out_shamt       (out_shamt),
        .out_funct       (out_funct),
        .out_imm         (out_imm),
        .out_jump_target (out_jump_target),
        .out_itype       (out_itype),
        .out_pc          (out_pc),
        .count           (count)
`ifdef DECODE_STATS_EN
        ,
        .stat_r          (stat_r),
        .stat_i          (stat_i),
        .stat_j          (stat_j)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int itype_of(input logic [31:0] w);
        int op = int'(w >> 26);
        if (op == 0) return 0;
        if (op == 2 || op == 3) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] w);
        int unsigned op = w >> 26;
        logic [31:0] v = w & 32'h0000_FFFF;
        if (!(op >= 12 && op <= 14) && v >= 32'h8000) v = v - 32'h0001_0000;
        return v;
    endfunction

    task automatic check_outputs();
        logic [31:0] w;
        logic [31:0] p;
        check("out_valid", out_valid, q_instr.size() > 0);
        check("count", count, q_instr.size());
        check("in_ready", in_ready, q_instr.size() < DEPTH);
        if (q_instr.size() > 0) begin
            w = q_instr[0];
            p = q_pc[0];
            check("opcode", out_opcode, w >> 26);
            check("rs", out_rs, (w >> 21) & 31);
            check("rt", out_rt, (w >> 16) & 31);
            check("rd", out_rd, (w >> 11) & 31);
            check("shamt", out_shamt, (w >> 6) & 31);
            check("funct", out_funct, w & 63);
            check("itype", out_itype, itype_of(w));
            check("imm", out_imm, imm_of(w));
            check("jump_target", out_jump_target,
                  ((p + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2));
            check("out_pc", out_pc, p);
        end else begin
            check("empty_fields", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_itype}, 0);
            check("empty_words", out_imm | out_jump_target | out_pc, 0);
        end
`ifdef DECODE_STATS_EN
        check("stat_r", stat_r, m_r);
        check("stat_i", stat_i, m_i);
        check("stat_j", stat_j, m_j);
`endif
    endtask

    // Drive one cycle's inputs, check the current outputs, then advance the model across the edge.
    task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic r, input logic f);
        bit do_push;
        bit do_pop;
        in_valid       = v;
        in_instruction = i;
        in_pc          = p;
        out_ready      = r;
        flush          = f;
        check_outputs();
        do_push = v && (q_instr.size() < DEPTH);
        do_pop  = r && (q_instr.size() > 0);
        @(posedge clk);
        if (f) begin
            q_instr.delete();
            q_pc.delete();
        end else begin
            if (do_pop) begin
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
            end
            if (do_push) begin
                q_instr.push_back(i);
                q_pc.push_back(p);
`ifdef DECODE_STATS_EN
                case (itype_of(i))
                    0:       m_r++;
                    2:       m_j++;
                    default: m_i++;
                endcase
`endif
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 6))
            0:       w[31:26] = 6'h00;
            1:       w[31:26] = 6'h02;
            2:       w[31:26] = 6'h03;
            3:       w[31:26] = 6'h0C;
            4:       w[31:26] = 6'h0D;
            5:       w[31:26] = 6'h0E;
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p = $urandom;
        if ($urandom_range(0, 3) == 0) p[27:0] = 28'hFFF_FFFC;
        return p;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Basic I-type
        cycle(1, 32'h2011_0005, 32'h0040_0000, 1, 0);
        check("basic_valid", out_valid, 1);
        check("basic_itype", out_itype, 1);
        check("basic_rs", out_rs, 0);
        check("basic_rt", out_rt, 17);
        check("basic_imm", out_imm, 32'h0000_0005);
        cycle(0, 0, 0, 1, 0);

        // Sign vs zero extension
        cycle(1, 32'h2008_8000, 32'h0040_0004, 1, 0);
        check("sext_imm", out_imm, 32'hFFFF_8000);
        cycle(1, 32'h3408_8000, 32'h0040_0008, 1, 0);
        check("zext_imm", out_imm, 32'h0000_8000);

        // J-type then R-type
        cycle(1, 32'h0810_0000, 32'h1000_0000, 1, 0);
        check("j_itype", out_itype, 2);
        check("j_target", out_jump_target, 32'h1040_0000);
        cycle(1, 32'h012A_4020, 32'h1000_0004, 1, 0);
        check("r_itype", out_itype, 0);
        check("r_rd", out_rd, 8);
        check("r_funct", out_funct, 6'h20);
        cycle(0, 0, 0, 1, 0);

        // Backpressure: third push is held off while full
        cycle(1, 32'h2001_0001, 32'h0000_0100, 0, 0);
        cycle(1, 32'h2002_0002, 32'h0000_0104, 0, 0);
        check("bp_in_ready", in_ready, 0);
        check("bp_count", count, 2);
        cycle(1, 32'h2003_0003, 32'h0000_0108, 0, 0);
        check("bp_head_pc", out_pc, 32'h0000_0100);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        check("bp_second_pc", out_pc, 32'h0000_0104);
        cycle(0, 0, 0, 1, 0);

        // Flush while full with a push pending
        cycle(1, 32'h2004_0004, 32'h0000_0200, 0, 0);
        cycle(1, 32'h2005_0005, 32'h0000_0204, 0, 0);
        cycle(1, 32'h2006_0006, 32'h0000_0208, 1, 1);
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        cycle(1, 32'h2007_0007, 32'h0000_0300, 0, 0);
        cycle(1, 32'h0000_0020, 32'h0000_0304, 1, 1);
        check("flush_push_dropped", count, 0);

        // Asynchronous reset mid-operation
        cycle(1, 32'h2008_0008, 32'h0000_0400, 0, 0);
        cycle(1, 32'h2009_0009, 32'h0000_0404, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_count", count, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_pc", out_pc, 0);
        q_instr.delete();
        q_pc.delete();
`ifdef DECODE_STATS_EN
        m_r = 0; m_i = 0; m_j = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef DECODE_STATS_EN
        cycle(1, 32'h012A_4020, 32'h0, 1, 0);
        cycle(1, 32'h2011_0005, 32'h4, 1, 0);
        cycle(1, 32'h3408_8000, 32'h8, 1, 0);
        cycle(1, 32'h0810_0000, 32'hC, 1, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 32'h2011_0005, 32'h10, 1, 0);
        check("stats_r", stat_r, 1);
        check("stats_i", stat_i, 3);
        check("stats_j", stat_j, 1);
`endif

        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), rand_pc(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered MIPS instruction-decode stage with valid/ready handshakes on both sides.
- Splits each 32-bit instruction into its fields and classifies it as R/I/J.
- Produces an extended immediate and an absolute jump target.
- Buffers decoded records in a parametrised FIFO between fetch and register-read, so fetch stalls only when the buffer is full.

Parameters:
- IMM_WIDTH, 32: width of the extended immediate output; must be >= 16.
- DEPTH, 2: number of decoded records buffered; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all buffered records.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; equals !full, no combinational path from out_ready.
- in_instruction  in  32  raw instruction word.
- in_pc  in  32  address of the instruction.
- out_valid  out  1  head record valid (FIFO not empty).
- out_ready  in  1  consumer accepts the head record.
- out_opcode  out  6  instruction[31:26].
- out_rs  out  5  instruction[25:21].
- out_rt  out  5  instruction[20:16].
- out_rd  out  5  instruction[15:11].
- out_shamt  out  5  instruction[10:6].
- out_funct  out  6  instruction[5:0].
- out_imm  out  IMM_WIDTH  extended instruction[15:0].
- out_jump_target  out  32  {pc+4[31:28], instruction[25:0], 2'b00}.
- out_itype  out  2  0 = R, 1 = I, 2 = J.
- out_pc  out  32  pc of the head record.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, rst_n low): FIFO empty, count=0, out_valid=0, in_ready=1. All data outputs read 0 while empty.
- Push: in_valid && in_ready at a clock edge. The decoded record is written at the tail; decode is purely combinational on the input side before storage.
- Pop: out_valid && out_ready at a clock edge. The head advances.
- Latency: an instruction accepted at edge N is visible on the outputs with out_valid=1 after edge N, when the FIFO was empty.
- Simultaneous push and pop: count unchanged. Allowed only while not full, since in_ready=!full; when full, a pop frees space for the next cycle only.
- Full (count==DEPTH): in_ready=0; in_valid is ignored.
- Empty: out_valid=0; out_ready is ignored.
- Pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- flush: next edge sets count=0 and empties the FIFO. It overrides a same-cycle push and pop; the pushed instruction is dropped.
- Reset mid-operation: all records are lost immediately; outputs return to the reset values.
- Classification:
  - opcode 0x00 -> R.
  - opcode 0x02 or 0x03 -> J.
  - all other opcodes -> I.
- Immediate extension:
  - zero-extend for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori).
  - sign-extend instruction[15] to IMM_WIDTH otherwise.
- pc+4 is computed modulo 2^32.
- out_* fields always show the head record; they are stable while out_valid && !out_ready.

Optional Feature:
- Macro: DECODE_STATS_EN.
- Defined: adds outputs stat_r, stat_i, stat_j, each 32 bits.
  - Each increments on a push of its class and wraps at 2^32.
  - Reset to 0 by rst_n; flush does not clear them.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Shared package decode_pkg:
  - itype encoding constants ITYPE_R/I/J.
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI.
  - decoded-record field widths.
- One sub-module, decode_fields: combinational field split, classify and extend. It is instantiated on the input side, so the FIFO stores decoded records.
- The FIFO storage and pointer logic live inline in decode_stage.

Test Plan:
- Basic I-type: push 0x20110005, pc 0x00400000, out_ready=1 -> next cycle out_valid=1, itype=1, rs=0, rt=17, out_imm=0x00000005.
- Extension rule: push 0x20088000 -> out_imm=0xFFFF8000. Then push 0x34088000 -> out_imm=0x00008000.
- J-type: push 0x08100000 with pc 0x10000000 -> itype=2, out_jump_target=0x10400000. Push 0x012A4020 -> itype=0, rd=8, funct=0x20.
- Backpressure (DEPTH=2, out_ready=0): push 3 instructions back-to-back -> in_ready falls after the 2nd, count=2, the 3rd is held. Raise out_ready -> records exit in order, each stable until popped.
- Flush: with count=2, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, the pushed word is dropped.
- Stats (DECODE_STATS_EN defined): push R, I, I, J, flush, then push I -> stat_r=1, stat_i=3, stat_j=1.
